// File: rtl/timer_alarm_pkg.sv
// Shared constants for the timer/alarm bank: FSM state codes, time-field indices
// and a small helper used to size the shared tick counter.
package timer_alarm_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RINGING = 2'd2;
    localparam logic [1:0] ST_SNOOZE  = 2'd3;

    localparam int FLD_SEC = 0;
    localparam int FLD_MIN = 1;
    localparam int FLD_HR  = 2;

    localparam int FIELD_W_DEFAULT = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/timer_tick_counter.sv
// Tick counter shared by the ring timeout and the snooze period; done flags the
// tick that brings the count up to the terminal value.
module timer_tick_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick_en,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   count_inc;

    always_comb begin
        count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
        done      = tick_en && (count_inc == {1'b0, terminal});
        count_d   = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick_en) begin
            count_d = count_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timer_alarm_bank.sv
// Multi-field BCD alarm setpoint with an edge-triggered armed/ringing/snooze FSM.
// Snooze support is compiled in with ALARM_SNOOZE_EN.
module timer_alarm_bank
    import timer_alarm_pkg::*;
#(
    parameter int NUM_FIELDS   = 3,
    parameter int FIELD_W      = FIELD_W_DEFAULT,
    parameter int RING_TICKS   = 30,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              hold,
    input  logic                                              chip_select,
    input  logic                                              wr_en,
    input  logic [((NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1)-1:0] wr_field,
    input  logic [FIELD_W-1:0]                                in_rtc_dato,
    input  logic [FIELD_W-1:0]                                in_count_dato,
    input  logic [NUM_FIELDS*FIELD_W-1:0]                     in_time,
    input  logic                                              tick,
    input  logic                                              arm,
    input  logic                                              btn_desactivar,
    input  logic                                              btn_snooze,
    input  logic                                              show_live,
    output logic [NUM_FIELDS*FIELD_W-1:0]                     out_dato_vga,
    output logic                                              flag_out,
    output logic [1:0]                                        state_out
);

    localparam int IDX_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int MAX_TICKS = max_int(RING_TICKS, SNOOZE_TICKS);
    localparam int CNT_W     = (MAX_TICKS > 0) ? $clog2(MAX_TICKS + 1) : 1;

    logic [NUM_FIELDS-1:0][FIELD_W-1:0] setpoint_q, setpoint_d;
    logic [FIELD_W-1:0] wr_data;
    logic               match_comb, match_q, match_d, rise;
    logic [1:0]         state_q, state_d;
    logic               flag_q, flag_d;
    logic               cnt_clear, cnt_tick_en, cnt_done, ring_timeout;
    logic [CNT_W-1:0]   cnt_terminal;

    // Setpoint only changes while the alarm is idle, so an armed compare is stable.
    always_comb begin
        wr_data    = chip_select ? in_count_dato : in_rtc_dato;
        setpoint_d = setpoint_q;
        if (wr_en && !hold && (state_q == ST_IDLE)) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (wr_field == IDX_W'(i)) begin
                    setpoint_d[i] = wr_data;
                end
            end
        end
    end

    assign match_comb   = (in_time == setpoint_q);
    assign rise         = match_q & ~match_d;
    assign out_dato_vga = show_live ? in_time : setpoint_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            setpoint_q <= '0;
            match_q    <= 1'b0;
            match_d    <= 1'b0;
            state_q    <= ST_IDLE;
            flag_q     <= 1'b0;
        end else begin
            setpoint_q <= setpoint_d;
            match_q    <= match_comb;
            match_d    <= match_q;
            state_q    <= state_d;
            flag_q     <= flag_d;
        end
    end

    assign cnt_clear    = (state_d != state_q);
    assign cnt_tick_en  = tick && ((state_q == ST_RINGING) || (state_q == ST_SNOOZE));
    assign cnt_terminal = (state_q == ST_SNOOZE) ? CNT_W'(SNOOZE_TICKS) : CNT_W'(RING_TICKS);
    assign ring_timeout = (RING_TICKS != 0) && cnt_done && (state_q == ST_RINGING);

    timer_tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .tick_en  (cnt_tick_en),
        .terminal (cnt_terminal),
        .done     (cnt_done)
    );

    // Acknowledge always takes priority over any other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arm) state_d = ST_ARMED;
            ST_ARMED: begin
                if (btn_desactivar)  state_d = ST_IDLE;
                else if (rise)       state_d = ST_RINGING;
            end
            ST_RINGING: begin
                if (btn_desactivar || ring_timeout) state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                else if (btn_snooze)                state_d = ST_SNOOZE;
`endif
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (btn_desactivar) state_d = ST_IDLE;
                else if (cnt_done)  state_d = ST_RINGING;
            end
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

`ifndef ALARM_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = btn_snooze;
`endif

    always_comb begin
        flag_d    = (state_d == ST_RINGING);
        flag_out  = flag_q;
        state_out = state_q;
`ifndef ALARM_SNOOZE_EN
        if (state_q == ST_SNOOZE) state_out = ST_IDLE;
`endif
    end

endmodule

// File: tb/tb_timer_alarm_bank.sv
// Directed bench for timer_alarm_bank: a per-cycle vector table followed by
// hand-written ring-timeout, snooze and reset sequences.
module tb_timer_alarm_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold, chip_select, wr_en;
    logic [1:0]  wr_field;
    logic [7:0]  in_rtc_dato, in_count_dato;
    logic [23:0] in_time;
    logic        tick, arm, btn_desactivar, btn_snooze, show_live;
    logic [23:0] out_dato_vga;
    logic        flag_out;
    logic [1:0]  state_out;

    int errors = 0;
    int checks = 0;

    localparam logic [23:0] T_SET  = 24'h071530;
    localparam logic [23:0] T_OTHR = 24'h123456;

    typedef struct {
        logic        hold, cs, wr_en;
        logic [1:0]  wr_field;
        logic [7:0]  rtc, cnt;
        logic [23:0] tim;
        logic        tick, arm, desact, snooze, show_live;
        logic [1:0]  exp_state;
        logic        exp_flag;
        logic [23:0] exp_vga;
    } vec_t;

    vec_t tbl[$];

    timer_alarm_bank #(
        .NUM_FIELDS   (3),
        .FIELD_W      (8),
        .RING_TICKS   (3),
        .SNOOZE_TICKS (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hold           (hold),
        .chip_select    (chip_select),
        .wr_en          (wr_en),
        .wr_field       (wr_field),
        .in_rtc_dato    (in_rtc_dato),
        .in_count_dato  (in_count_dato),
        .in_time        (in_time),
        .tick           (tick),
        .arm            (arm),
        .btn_desactivar (btn_desactivar),
        .btn_snooze     (btn_snooze),
        .show_live      (show_live),
        .out_dato_vga   (out_dato_vga),
        .flag_out       (flag_out),
        .state_out      (state_out)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic h, input logic cs, input logic we,
                                input logic [1:0] fld, input logic [7:0] rtc,
                                input logic [7:0] cnt, input logic [23:0] tim,
                                input logic tk, input logic ar, input logic de,
                                input logic sn, input logic sl,
                                input logic [1:0] es, input logic ef,
                                input logic [23:0] ev);
        vec_t v;
        v.hold = h; v.cs = cs; v.wr_en = we; v.wr_field = fld;
        v.rtc = rtc; v.cnt = cnt; v.tim = tim; v.tick = tk; v.arm = ar;
        v.desact = de; v.snooze = sn; v.show_live = sl;
        v.exp_state = es; v.exp_flag = ef; v.exp_vga = ev;
        return v;
    endfunction

    // Idle-input vector: only time/controls given, no write.
    function automatic vec_t ctl(input logic [23:0] tim, input logic tk,
                                 input logic ar, input logic de, input logic sn,
                                 input logic [1:0] es, input logic ef);
        return mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, tim, tk, ar, de, sn, 1'b0,
                  es, ef, T_SET);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        hold = v.hold; chip_select = v.cs; wr_en = v.wr_en; wr_field = v.wr_field;
        in_rtc_dato = v.rtc; in_count_dato = v.cnt; in_time = v.tim; tick = v.tick;
        arm = v.arm; btn_desactivar = v.desact; btn_snooze = v.snooze;
        show_live = v.show_live;
        @(posedge clk);
        #1;
        check({tag, ".state"}, 32'(state_out), 32'(v.exp_state));
        check({tag, ".flag"}, 32'(flag_out), 32'(v.exp_flag));
        check({tag, ".vga"}, 32'(out_dato_vga), 32'(v.exp_vga));
    endtask

    // From IDLE with setpoint T_SET: arm away from the setpoint, then present it.
    task automatic make_ringing(input string tag);
        run_vec({tag, ".arm"},  ctl(T_OTHR, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        run_vec({tag, ".eq"},   ctl(T_SET,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0));
        run_vec({tag, ".ring"}, ctl(T_SET,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1));
    endtask

    initial begin
        // Clock/reset block
        reset = 1'b1; hold = 1'b0; chip_select = 1'b0; wr_en = 1'b0; wr_field = 2'd0;
        in_rtc_dato = 8'h00; in_count_dato = 8'h00; in_time = T_OTHR; tick = 1'b0;
        arm = 1'b0; btn_desactivar = 1'b0; btn_snooze = 1'b0; show_live = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.state", 32'(state_out), 32'd0);
        check("rst.flag", 32'(flag_out), 32'd0);
        check("rst.vga", 32'(out_dato_vga), 32'd0);
        reset = 1'b0;

        // hold cs we fld rtc cnt time tick arm de sn sl | state flag vga
        tbl.push_back(mk(0,1,1,2'd0,8'h99,8'h30,T_OTHR,0,0,0,0,0, 2'd0,0,24'h000030));
        tbl.push_back(mk(0,1,1,2'd1,8'h99,8'h15,T_OTHR,0,0,0,0,0, 2'd0,0,24'h001530));
        tbl.push_back(mk(0,1,1,2'd2,8'h99,8'h07,T_OTHR,0,0,0,0,0, 2'd0,0,24'h071530));
        tbl.push_back(mk(0,1,1,2'd3,8'h55,8'h55,T_OTHR,0,0,0,0,0, 2'd0,0,24'h071530));
        tbl.push_back(mk(1,1,1,2'd1,8'h45,8'h45,T_OTHR,0,0,0,0,0, 2'd0,0,24'h071530));
        tbl.push_back(mk(0,0,1,2'd0,8'h31,8'h99,T_OTHR,0,0,0,0,0, 2'd0,0,24'h071531));
        tbl.push_back(mk(0,0,1,2'd0,8'h30,8'h99,T_OTHR,0,0,0,0,0, 2'd0,0,24'h071530));
        tbl.push_back(mk(0,0,0,2'd0,8'h00,8'h00,T_OTHR,0,1,0,0,0, 2'd1,0,24'h071530));
        tbl.push_back(mk(0,1,1,2'd1,8'h45,8'h45,T_OTHR,0,0,0,0,1, 2'd1,0,T_OTHR));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd1,0));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd2,1));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd2,1));
        tbl.push_back(ctl(T_SET,  0,0,1,0, 2'd0,0));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd0,0));
        tbl.push_back(ctl(T_SET,  0,1,0,0, 2'd1,0));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd1,0));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd1,0));
        tbl.push_back(ctl(T_OTHR, 0,0,0,0, 2'd1,0));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd1,0));
        tbl.push_back(ctl(T_SET,  0,1,1,0, 2'd0,0));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd0,0));
        tbl.push_back(ctl(T_SET,  0,1,0,0, 2'd1,0));
        tbl.push_back(ctl(T_OTHR, 0,0,0,0, 2'd1,0));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd1,0));
        tbl.push_back(ctl(T_SET,  0,0,0,0, 2'd2,1));
        tbl.push_back(ctl(T_SET,  0,0,1,0, 2'd0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Ring timeout after the third tick, with a tick-free cycle in between
        make_ringing("to");
        run_vec("to.t1",   ctl(T_SET, 1,0,0,0, 2'd2,1));
        run_vec("to.t2",   ctl(T_SET, 1,0,0,0, 2'd2,1));
        run_vec("to.gap",  ctl(T_SET, 0,0,0,0, 2'd2,1));
        run_vec("to.t3",   ctl(T_SET, 1,0,0,0, 2'd0,0));
        run_vec("to.idle", ctl(T_SET, 1,0,0,0, 2'd0,0));

        // Acknowledge coinciding with the terminal tick
        make_ringing("ack");
        run_vec("ack.t1",  ctl(T_SET, 1,0,0,0, 2'd2,1));
        run_vec("ack.t2",  ctl(T_SET, 1,0,0,0, 2'd2,1));
        run_vec("ack.t3",  ctl(T_SET, 1,0,1,0, 2'd0,0));

        // Snooze request
        make_ringing("sn");
`ifdef ALARM_SNOOZE_EN
        run_vec("sn.req",  ctl(T_SET, 0,0,0,1, 2'd3,0));
        run_vec("sn.t1",   ctl(T_SET, 1,0,0,0, 2'd3,0));
        run_vec("sn.t2",   ctl(T_SET, 1,0,0,0, 2'd2,1));
        run_vec("sn.t3",   ctl(T_SET, 1,0,0,0, 2'd2,1));
        run_vec("sn.ack",  ctl(T_SET, 0,0,1,0, 2'd0,0));
`else
        run_vec("sn.req",  ctl(T_SET, 0,0,0,1, 2'd2,1));
        run_vec("sn.hold", ctl(T_SET, 0,0,0,1, 2'd2,1));
        run_vec("sn.ack",  ctl(T_SET, 0,0,1,0, 2'd0,0));
`endif

        // Asynchronous reset in the middle of ringing
        make_ringing("mr");
        #2;
        reset = 1'b1;
        #1;
        check("mr.async_state", 32'(state_out), 32'd0);
        check("mr.async_flag", 32'(flag_out), 32'd0);
        @(posedge clk);
        #1;
        check("mr.state", 32'(state_out), 32'd0);
        check("mr.flag", 32'(flag_out), 32'd0);
        check("mr.vga", 32'(out_dato_vga), 32'd0);
        reset = 1'b0;
        run_vec("mr.after", mk(0,0,0,2'd0,8'h00,8'h00,T_SET,0,0,0,0,0, 2'd0,0,24'h000000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
